// File: rtl/pipelined_division.sv
// Fully pipelined unsigned restoring divider: one quotient bit per stage, MSB first.
// Accepts one operand pair per clock; q/r/out_valid appear A_WIDTH cycles after capture.
module pipelined_division #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  output logic [A_WIDTH-1:0] q,
  output logic [B_WIDTH-2:0] r
);

  // Returns {q_bit, new_rem}. The shifted remainder needs B_WIDTH+1 bits; after a
  // successful subtract the result is below the divisor, so B_WIDTH bits suffice.
  function automatic logic [B_WIDTH:0] div_step(input logic [B_WIDTH-1:0] rem,
                                                input logic               a_bit,
                                                input logic [B_WIDTH-1:0] dv);
    logic [B_WIDTH:0]   sh;
    logic [B_WIDTH-1:0] diff;
    logic               ge;
    sh   = {rem, a_bit};
    ge   = (sh >= {1'b0, dv});
    diff = sh[B_WIDTH-1:0] - dv;
    return {ge, (ge ? diff : sh[B_WIDTH-1:0])};
  endfunction

  for (genvar k = 0; k < A_WIDTH - 1; k++) begin : g_stg
    logic [B_WIDTH-1:0]   rem_in;
    logic [B_WIDTH-1:0]   div_in;
    logic [A_WIDTH-1-k:0] dvd_in;
    logic                 vld_in;
    logic [B_WIDTH:0]     step_d;
    logic [k:0]           quo_d;

    logic [B_WIDTH-1:0]   rem_q;
    logic [B_WIDTH-1:0]   div_q;
    logic [k:0]           quo_q;
    logic [A_WIDTH-2-k:0] dvd_q;
    logic                 vld_q;

    if (k == 0) begin : g_head
      assign rem_in = '0;
      assign div_in = b;
      assign dvd_in = a;
      assign vld_in = in_valid;
      assign quo_d  = step_d[B_WIDTH];
    end else begin : g_body
      assign rem_in = g_stg[k-1].rem_q;
      assign div_in = g_stg[k-1].div_q;
      assign dvd_in = g_stg[k-1].dvd_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign quo_d  = {g_stg[k-1].quo_q, step_d[B_WIDTH]};
    end

    assign step_d = div_step(rem_in, dvd_in[A_WIDTH-1-k], div_in);

    always_ff @(posedge clk) begin
      if (!nrst) begin
        vld_q <= 1'b0;
        rem_q <= '0;
        quo_q <= '0;
        dvd_q <= '0;
        div_q <= '0;
      end else begin
        vld_q <= vld_in;
        rem_q <= step_d[B_WIDTH-1:0];
        quo_q <= quo_d;
        dvd_q <= dvd_in[A_WIDTH-2-k:0];
        div_q <= div_in;
      end
    end
  end

  // Final stage drives the outputs directly; only the low B_WIDTH-1 remainder bits leave.
  localparam int unsigned LAST = A_WIDTH - 2;

  logic [B_WIDTH:0]   fin_d;
  logic               unused_rem_msb;
  logic               out_valid_q;
  logic [A_WIDTH-1:0] q_q;
  logic [B_WIDTH-2:0] r_q;

  assign fin_d          = div_step(g_stg[LAST].rem_q, g_stg[LAST].dvd_q[0], g_stg[LAST].div_q);
  assign unused_rem_msb = fin_d[B_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
    end else begin
      out_valid_q <= g_stg[LAST].vld_q;
      q_q         <= {g_stg[LAST].quo_q, fin_d[B_WIDTH]};
      r_q         <= fin_d[B_WIDTH-2:0];
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;

endmodule

// File: tb/tb_pipelined_division.sv
// Self-checking bench for pipelined_division: directed cases plus randomized stream
// compared against a plain-arithmetic reference with a fixed-latency schedule.
module tb_pipelined_division;
  localparam int AW = 16;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          out_valid;
  logic [AW-1:0] q;
  logic [BW-2:0] r;

  pipelined_division #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .q        (q),
    .r        (r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] q;
    logic [BW-2:0] r;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc    = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input int unsigned aa, input int unsigned bb, input int unsigned due);
    exp_t        e;
    int unsigned qv, rv;
    if (bb == 0) begin
      qv = (1 << AW) - 1;
      rv = aa;
    end else begin
      qv = aa / bb;
      rv = aa % bb;
    end
    e.due = due;
    e.q   = qv[AW-1:0];
    rv    = rv % (1 << (BW - 1));
    e.r   = rv[BW-2:0];
    return e;
  endfunction

  // One clock: record what the DUT captured at the edge, then check outputs mid-cycle.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!nrst) exp_q.delete();
    else if (in_valid) exp_q.push_back(model(a, b, cyc + AW - 1));
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("out_valid", out_valid, 1);
      chk("q", q, exp_q[0].q);
      chk("r", r, exp_q[0].r);
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_idle", out_valid, 0);
    end
  endtask

  task automatic issue(input int unsigned aa, input int unsigned bb);
    in_valid = 1'b1;
    a        = aa[AW-1:0];
    b        = bb[BW-1:0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    nrst = 1'b0;
    idle(2);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    nrst = 1'b1;

    issue(622, 3);
    idle(18);

    issue(100, 7);
    issue(65535, 1);
    issue(65535, 65535);
    issue(5, 9);
    idle(17);

    issue(1234, 0);
    idle(16);

    issue(65535, 40000);
    issue(49999, 50000);
    idle(17);

    issue(1000, 10);
    issue(2000, 20);
    issue(3000, 30);
    idle(4);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    idle(20);
    issue(9999, 77);
    idle(17);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        int unsigned ra, rb;
        ra = $urandom_range(0, 65535);
        if ($urandom_range(0, 1) == 0) rb = $urandom_range(1, 300);
        else rb = $urandom_range(1, 65535);
        issue(ra, rb);
      end
    end
    idle(20);
    chk("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
